ie_branch_unit: RTL
===================

IE_BRANCH_UNIT -- requirements
Module: ie_branch_unit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: start  in  1  request strobe, sampled only when busy=0.
REQ-004 SHALL have ports: op  in  8  IE op code: BCC 0x04, BCS 0x05, BEQ 0x06, BMI 0x07, BNE 0x08, BPL 0x09, BVC 0x0A, BVS 0x0B, JMP 0x1C.
REQ-005 SHALL have ports: indirect  in  1  JMP addressing select: 0 absolute, 1 indirect; ignored for branches.
REQ-006 SHALL have ports: operand  in  16  JMP address, or branch signed offset in [7:0].
REQ-007 SHALL have ports: pc_in  in  16  address of the instruction following the branch/JMP.
REQ-008 SHALL have ports: status  in  8  P register: C=bit0, Z=bit1, V=bit6, N=bit7.
REQ-009 SHALL have ports: mem_rd_en  out  1; mem_addr  out  16; mem_rd_data  in  8; mem_rd_valid  in  1  (read port).
REQ-010 SHALL have ports: busy  out  1; done  out  1; pc_load  out  1; pc_out  out  16; taken  out  1; extra_cycles  out  2; illegal  out  1.

Function
REQ-011 SHALL capture op, indirect, operand, pc_in, status on the rising edge where start=1 and busy=0; later input changes SHALL NOT affect the operation.
REQ-012 SHALL ignore start while busy=1; no queuing.
REQ-013 SHALL implement states IDLE, EVAL, PEN_TAKEN, PEN_PAGE, IND_LO, IND_HI, DONE; busy=1 in every state except IDLE.
REQ-014 IDLE->EVAL on accepted start; DONE->IDLE unconditionally.
REQ-015 EVAL, branch condition: BCC C=0, BCS C=1, BEQ Z=1, BNE Z=0, BMI N=1, BPL N=0, BVC V=0, BVS V=1.
REQ-016 Branch not taken: EVAL->DONE; pc_load=0, taken=0, extra_cycles=0.
REQ-017 Branch taken: target = pc_in + sign-extended operand[7:0], modulo 2^16; EVAL->PEN_TAKEN.
REQ-018 PEN_TAKEN->PEN_PAGE if target[15:8] != pc_in[15:8], else ->DONE; extra_cycles=1 same page, 2 page crossed.
REQ-019 JMP absolute: EVAL->DONE; pc_out=operand, pc_load=1, taken=1, extra_cycles=0.
REQ-020 JMP indirect: EVAL->IND_LO; drive mem_rd_en=1, mem_addr=operand; on mem_rd_valid latch low byte, ->IND_HI.
REQ-021 IND_HI: mem_addr = {operand[15:8], operand[7:0]+1 mod 256} (6502 page-wrap behaviour); on mem_rd_valid latch high byte, ->DONE.
REQ-022 mem_rd_en and mem_addr SHALL stay stable while waiting for mem_rd_valid; mem_rd_en=0 in all other states; wait is unbounded.
REQ-023 Unsupported op: EVAL->DONE with illegal=1, pc_load=0, taken=0.
REQ-024 done SHALL be high exactly one cycle (in DONE); pc_load, pc_out, taken, extra_cycles, illegal valid during that cycle, held until the next accepted start.
REQ-025 Latency from start edge to done: not-taken/JMP abs/illegal 2 cycles; taken same page 3; taken page-cross 4; JMP indirect 2 + two read waits.
REQ-026 start asserted in the DONE cycle SHALL be ignored (busy=1); accepted the following cycle.

Reset
REQ-027 rst=0 SHALL immediately force IDLE and drive busy, done, pc_load, taken, illegal, mem_rd_en=0, pc_out=0x0000, mem_addr=0x0000, extra_cycles=0, from any state including mid-read.
REQ-028 First accepted start SHALL be on the first rising edge with rst=1 and start=1.

Verification
REQ-029 BEQ, Z=1, pc_in=0x80F0, operand=0x0020 -> done 4 cycles after start, pc_out=0x8110, pc_load=1, extra_cycles=2.
REQ-030 BCC, C=0, pc_in=0x8010, operand=0x00F0 -> done at cycle 3, pc_out=0x8000, extra_cycles=1.
REQ-031 BNE, Z=1 -> done at cycle 2, pc_load=0, taken=0, extra_cycles=0.
REQ-032 JMP indirect, operand=0x02FF, mem[0x02FF]=0x34, mem[0x0200]=0x12, 3-cycle read latency -> reads at 0x02FF then 0x0200, pc_out=0x1234.
REQ-033 op=0x55 -> done at cycle 2 with illegal=1, pc_load=0; start pulsed while busy ignored.
REQ-034 rst=0 asserted during IND_HI -> all outputs reset same cycle, busy=0; start after release accepted normally.

Source files
------------

// File: rtl/ie_branch_unit.sv
// Branch / JMP resolution unit: evaluates conditional branches against the P
// flags, computes targets with page-cross penalties, and fetches JMP (ind) vectors.
module ie_branch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  op,
    input  logic        indirect,
    input  logic [15:0] operand,
    input  logic [15:0] pc_in,
    input  logic [7:0]  status,
    output logic        mem_rd_en,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rd_data,
    input  logic        mem_rd_valid,
    output logic        busy,
    output logic        done,
    output logic        pc_load,
    output logic [15:0] pc_out,
    output logic        taken,
    output logic [1:0]  extra_cycles,
    output logic        illegal
);

    localparam logic [7:0] OP_BCC = 8'h04;
    localparam logic [7:0] OP_BCS = 8'h05;
    localparam logic [7:0] OP_BEQ = 8'h06;
    localparam logic [7:0] OP_BMI = 8'h07;
    localparam logic [7:0] OP_BNE = 8'h08;
    localparam logic [7:0] OP_BPL = 8'h09;
    localparam logic [7:0] OP_BVC = 8'h0A;
    localparam logic [7:0] OP_BVS = 8'h0B;
    localparam logic [7:0] OP_JMP = 8'h1C;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_PEN_TAKEN,
        S_PEN_PAGE,
        S_IND_LO,
        S_IND_HI,
        S_DONE
    } state_t;

    state_t      state;
    logic [7:0]  op_reg;
    logic        indirect_reg;
    logic [15:0] operand_reg;
    logic [15:0] pc_reg;
    logic [7:0]  status_reg;
    logic [7:0]  lo_reg;

    logic        is_branch;
    logic        cond_met;
    logic [15:0] target;

    always_comb begin
        is_branch = 1'b1;
        cond_met  = 1'b0;
        case (op_reg)
            OP_BCC:  cond_met = ~status_reg[0];
            OP_BCS:  cond_met =  status_reg[0];
            OP_BEQ:  cond_met =  status_reg[1];
            OP_BNE:  cond_met = ~status_reg[1];
            OP_BMI:  cond_met =  status_reg[7];
            OP_BPL:  cond_met = ~status_reg[7];
            OP_BVC:  cond_met = ~status_reg[6];
            OP_BVS:  cond_met =  status_reg[6];
            default: is_branch = 1'b0;
        endcase
    end

    assign target = pc_reg + {{8{operand_reg[7]}}, operand_reg[7:0]};
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            op_reg       <= 8'h00;
            indirect_reg <= 1'b0;
            operand_reg  <= 16'h0000;
            pc_reg       <= 16'h0000;
            status_reg   <= 8'h00;
            lo_reg       <= 8'h00;
            mem_rd_en    <= 1'b0;
            mem_addr     <= 16'h0000;
            done         <= 1'b0;
            pc_load      <= 1'b0;
            pc_out       <= 16'h0000;
            taken        <= 1'b0;
            extra_cycles <= 2'd0;
            illegal      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_reg       <= op;
                        indirect_reg <= indirect;
                        operand_reg  <= operand;
                        pc_reg       <= pc_in;
                        status_reg   <= status;
                        pc_load      <= 1'b0;
                        taken        <= 1'b0;
                        extra_cycles <= 2'd0;
                        illegal      <= 1'b0;
                        state        <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (is_branch) begin
                        if (cond_met) begin
                            // Results are committed now; the penalty states only stretch latency.
                            pc_out       <= target;
                            pc_load      <= 1'b1;
                            taken        <= 1'b1;
                            extra_cycles <= 2'd1;
                            state        <= S_PEN_TAKEN;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else if (op_reg == OP_JMP) begin
                        if (indirect_reg) begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= operand_reg;
                            state     <= S_IND_LO;
                        end else begin
                            pc_out  <= operand_reg;
                            pc_load <= 1'b1;
                            taken   <= 1'b1;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end
                    end else begin
                        illegal <= 1'b1;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_PEN_TAKEN: begin
                    if (target[15:8] != pc_reg[15:8]) begin
                        extra_cycles <= 2'd2;
                        state        <= S_PEN_PAGE;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_PEN_PAGE: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_IND_LO: begin
                    if (mem_rd_valid) begin
                        lo_reg <= mem_rd_data;
                        // High byte comes from the same page: the low address byte wraps.
                        mem_addr <= {operand_reg[15:8], operand_reg[7:0] + 8'd1};
                        state    <= S_IND_HI;
                    end
                end
                S_IND_HI: begin
                    if (mem_rd_valid) begin
                        mem_rd_en <= 1'b0;
                        pc_out    <= {mem_rd_data, lo_reg};
                        pc_load   <= 1'b1;
                        taken     <= 1'b1;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
